matrix_result_writer: RTL and testbench

Downstream sink for the matrix operation units (add, and later sub/mul/transpose). It accepts a write request with result metadata, writes the metadata header into the target matrix block of the matrix BRAM, then streams result elements into the block's data region over a valid/ready handshake. It signals completion with a one-cycle `write_done` pulse. It is the single write master into matrix storage for operation results.

---
 rtl/matrix_result_writer.sv | 167 ++++++++++++++++
 tb/tb_matrix_result_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_writer.sv
// matrix_result_writer: single write master for matrix op results.
// Writes the block header, then streams elements into the data region.

package matrix_pkg;
    localparam int MATRIX_BLOCK_SIZE     = 256;
    localparam int MATRIX_ADDR_WIDTH     = 11;
    localparam int MATRIX_DATA_WIDTH     = 32;
    localparam int MATRIX_METADATA_WORDS = 4;
endpackage

module matrix_result_writer
    import matrix_pkg::*;
#(
    parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
    parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
    parameter int META_WORDS = MATRIX_METADATA_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            actual_rows,
    input  logic [7:0]            actual_cols,
    input  logic [0:7][7:0]       matrix_name,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int KW = $clog2(META_WORDS + 1);
    localparam int CAP = BLOCK_SIZE - META_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        META,
        STREAM,
        DONE
    } state_t;

    state_t state, state_d;

    logic [2:0]            id_q;
    logic [7:0]            rows_q;
    logic [7:0]            cols_q;
    logic [0:7][7:0]       name_q;
    logic [15:0]           count_q;
    logic [15:0]           idx_q;
    logic [KW-1:0]         meta_k;
    logic                  err_q;

    logic [15:0]           cnt_in;
    logic                  err_in;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  meta_last;
    logic                  elem_last;

    assign cnt_in = 16'(actual_rows) * 16'(actual_cols);
    assign err_in = (cnt_in == 16'd0) ||
                    ({16'd0, cnt_in} > 32'(CAP));
    assign base = ADDR_WIDTH'(32'(id_q) * 32'(BLOCK_SIZE));
    assign meta_last = (meta_k == KW'(META_WORDS - 1));
    assign elem_last = (idx_q == count_q - 16'd1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Request latch, header/element counters and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            name_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            meta_k  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_request) begin
                        id_q    <= matrix_id;
                        rows_q  <= actual_rows;
                        cols_q  <= actual_cols;
                        name_q  <= matrix_name;
                        count_q <= cnt_in;
                        idx_q   <= '0;
                        meta_k  <= '0;
                        err_q   <= err_in;
                    end
                end
                META: meta_k <= meta_k + KW'(1);
                STREAM: begin
                    if (data_valid) idx_q <= idx_q + 16'd1;
                end
                DONE: err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

    // Header word selected by the header counter.
    always_comb begin
        hdr_word = '0;
        unique case (1'b1)
            (meta_k == KW'(0)):
                hdr_word = DATA_WIDTH'({rows_q, cols_q});
            (meta_k == KW'(1)):
                hdr_word = DATA_WIDTH'({name_q[3], name_q[2],
                                        name_q[1], name_q[0]});
            (meta_k == KW'(2)):
                hdr_word = DATA_WIDTH'({name_q[7], name_q[6],
                                        name_q[5], name_q[4]});
            default: hdr_word = '0;
        endcase
    end

    // Next state and all outputs.
    always_comb begin
        state_d      = state;
        write_ready  = 1'b0;
        writer_ready = 1'b0;
        write_done   = 1'b0;
        write_error  = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        unique case (state)
            IDLE: begin
                write_ready = 1'b1;
                if (write_request) state_d = err_in ? DONE : META;
            end
            META: begin
                mem_we    = 1'b1;
                mem_addr  = base + ADDR_WIDTH'(meta_k);
                mem_wdata = hdr_word;
                if (meta_last) state_d = STREAM;
            end
            STREAM: begin
                writer_ready = 1'b1;
                mem_we       = data_valid;
                mem_addr     = base + ADDR_WIDTH'(META_WORDS)
                             + ADDR_WIDTH'(idx_q);
                mem_wdata    = data_in;
                if (data_valid && elem_last) state_d = DONE;
            end
            DONE: begin
                write_done  = 1'b1;
                write_error = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_result_writer.sv
// tb_matrix_result_writer: table vectors, corner sequences and random
// transactions checked against a memory-image reference model.

module tb_matrix_result_writer;

    localparam int BS = 64;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int M  = 4;
    localparam int MEMSZ = 512;

    typedef struct {
        logic [2:0]      id;
        logic [7:0]      rows;
        logic [7:0]      cols;
        logic [0:7][7:0] name;
        int              bub;
        bit              noise;
        bit              seq;
        bit              exp_err;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            write_request;
    logic            write_ready;
    logic [2:0]      matrix_id;
    logic [7:0]      actual_rows;
    logic [7:0]      actual_cols;
    logic [0:7][7:0] matrix_name;
    logic [DW-1:0]   data_in;
    logic            data_valid;
    logic            writer_ready;
    logic            write_done;
    logic            write_error;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    logic [31:0] dut_mem [MEMSZ] = '{default: '0};
    logic [31:0] exp_mem [MEMSZ] = '{default: '0};

    matrix_result_writer #(
        .BLOCK_SIZE(BS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .META_WORDS(M)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_request(write_request),
        .write_ready  (write_ready),
        .matrix_id    (matrix_id),
        .actual_rows  (actual_rows),
        .actual_cols  (actual_cols),
        .matrix_name  (matrix_name),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .writer_ready (writer_ready),
        .write_done   (write_done),
        .write_error  (write_error),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata)
    );

    always #5 clk = ~clk;

    // Memory written at a posedge is captured mid-cycle beforehand.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            dut_mem[int'(mem_addr)] = mem_wdata;
            wr_cnt++;
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_image(input string nm);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < MEMSZ; a++) begin
            if (dut_mem[a] !== exp_mem[a]) begin
                if (first < 0) first = a;
                bad++;
            end
        end
        check(nm, 64'(bad), 64'd0);
        if (first >= 0)
            $display("  first diff addr %0d got %0h want %0h",
                     first, dut_mem[first], exp_mem[first]);
    endtask

    function automatic bit model_err(input logic [7:0] r,
                                     input logic [7:0] c);
        int n;
        n = int'(r) * int'(c);
        return (n == 0) || (n > BS - M);
    endfunction

    function automatic vec_t mk(input logic [2:0] id, input int r,
                                input int c, input logic [63:0] nm,
                                input int bub, input bit noise,
                                input bit e);
        vec_t v;
        v.id = id;
        v.rows = 8'(r);
        v.cols = 8'(c);
        v.name = nm;
        v.bub = bub;
        v.noise = noise;
        v.seq = 1'b1;
        v.exp_err = e;
        return v;
    endfunction

    task automatic run_tx(input vec_t v, input int abort_after);
        int cnt;
        int sent;
        int budget;
        int base;
        int w0;
        logic [31:0] elems [$];
        cnt = int'(v.rows) * int'(v.cols);
        base = (int'(v.id) * BS) % MEMSZ;
        budget = 0;
        @(negedge clk);
        while (write_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("ready_before_req", 64'(write_ready), 64'd1);
        @(posedge clk); #1;
        write_request = 1'b1;
        matrix_id = v.id;
        actual_rows = v.rows;
        actual_cols = v.cols;
        matrix_name = v.name;
        w0 = wr_cnt;
        @(negedge clk);
        check("accept_ready", 64'(write_ready), 64'd1);
        @(posedge clk); #1;
        write_request = 1'b0;
        matrix_id = 3'($urandom);
        actual_rows = 8'($urandom);
        actual_cols = 8'($urandom);
        matrix_name = {$urandom, $urandom};
        if (v.exp_err) begin
            @(negedge clk);
            check("reject_done_err", {write_done, write_error}, 2'b11);
            @(posedge clk); #1;
            @(negedge clk);
            check("reject_ready", {write_ready, write_done}, 2'b10);
            check("reject_writes", 64'(wr_cnt - w0), 64'd0);
            cmp_image("reject_image");
            return;
        end
        exp_mem[base] = {16'h0, v.rows, v.cols};
        exp_mem[base + 1] = {v.name[3], v.name[2], v.name[1], v.name[0]};
        exp_mem[base + 2] = {v.name[7], v.name[6], v.name[5], v.name[4]};
        for (int k = 3; k < M; k++) exp_mem[base + k] = '0;
        for (int i = 0; i < cnt; i++)
            elems.push_back(v.seq ? 32'(i + 1) : $urandom);
        for (int k = 0; k < M; k++) begin
            if (v.noise) begin
                data_valid = 1'b1;
                data_in = 32'hDEAD_0000 + 32'(k);
                write_request = (k == 1);
                matrix_id = ~v.id;
            end
            @(negedge clk);
            check("meta_flags", {writer_ready, write_done, write_ready},
                  3'b000);
            @(posedge clk); #1;
            write_request = 1'b0;
            data_valid = 1'b0;
        end
        check("meta_writes", 64'(wr_cnt - w0), 64'(M));
        sent = 0;
        budget = 0;
        while (sent < cnt && budget < 4 * cnt + 20) begin
            unique case (v.bub)
                0: data_valid = 1'b1;
                1: data_valid = (budget % 2 == 0);
                default: data_valid = 1'($urandom);
            endcase
            data_in = elems[sent];
            @(negedge clk);
            check("stream_ready", {writer_ready, write_done}, 2'b10);
            if (data_valid) begin
                exp_mem[base + M + sent] = elems[sent];
                sent++;
            end
            budget++;
            @(posedge clk); #1;
            if (abort_after > 0 && sent == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_ctl",
                      {write_ready, writer_ready, write_done,
                       write_error, mem_we}, 5'b10000);
                check("abort_addr_data", {mem_addr, mem_wdata}, '0);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("abort_no_done", 64'(write_done), 64'd0);
                end
                data_valid = 1'b0;
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("abort_post_idle", {write_ready, write_done}, 2'b10);
                check("abort_writes", 64'(wr_cnt - w0),
                      64'(M + abort_after));
                cmp_image("abort_image");
                return;
            end
        end
        check("stream_count", 64'(sent), 64'(cnt));
        data_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", {write_done, write_error, write_ready}, 3'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after", {write_ready, write_done}, 2'b10);
        check("total_writes", 64'(wr_cnt - w0), 64'(M + cnt));
        cmp_image("mem_image");
    endtask

    vec_t tbl [8];
    vec_t rv;
    logic [63:0] addres;

    initial begin
        addres = {"ADDRES", 16'h0};
        tbl[0] = mk(3'd2, 2, 3, addres, 0, 1'b0, 1'b0);
        tbl[1] = mk(3'd2, 2, 3, addres, 1, 1'b0, 1'b0);
        tbl[2] = mk(3'd5, 0, 5, addres, 0, 1'b0, 1'b1);
        tbl[3] = mk(3'd1, 255, 255, addres, 0, 1'b0, 1'b1);
        tbl[4] = mk(3'd7, 1, 1, "MIN1X1", 0, 1'b0, 1'b0);
        tbl[5] = mk(3'd0, 6, 10, "FULLBLK!", 2, 1'b0, 1'b0);
        tbl[6] = mk(3'd3, 61, 1, "OVER", 0, 1'b0, 1'b1);
        tbl[7] = mk(3'd4, 3, 2, "NOISY", 0, 1'b1, 1'b0);

        rst_n = 1'b0;
        write_request = 1'b0;
        matrix_id = '0;
        actual_rows = '0;
        actual_cols = '0;
        matrix_name = '0;
        data_in = '0;
        data_valid = 1'b1;
        #12;
        check("reset_ctl",
              {write_ready, writer_ready, write_done, write_error, mem_we},
              5'b10000);
        check("reset_addr_data", {mem_addr, mem_wdata}, '0);
        data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_tx(tbl[i], 0);

        rv = mk(3'd6, 2, 3, "ABORTED", 0, 1'b0, 1'b0);
        run_tx(rv, 3);
        rv = mk(3'd6, 2, 3, "AFTER", 0, 1'b0, 1'b0);
        run_tx(rv, 0);

        for (int i = 0; i < 12; i++) begin
            rv.id = 3'($urandom);
            rv.rows = 8'($urandom_range(0, 8));
            rv.cols = 8'($urandom_range(0, 8));
            rv.name = {$urandom, $urandom};
            rv.bub = $urandom_range(0, 2);
            rv.noise = 1'($urandom);
            rv.seq = 1'b0;
            rv.exp_err = model_err(rv.rows, rv.cols);
            run_tx(rv, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
